// File: rtl/gcm_stream_ctrl.sv
// Packet sequencer between a 128-bit host stream and the gcm core: decodes OP, loads and
// expands the key, forwards IV/AADLEN/AAD/data to gcm and queues gcm results in an output FIFO.
module gcm_stream_ctrl #(
    parameter int BLK_BITS       = 128,
    parameter int KEY_BITS       = 256,
    parameter int OUT_FIFO_DEPTH = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [BLK_BITS-1:0] s_tdata,
    input  logic                s_tvalid,
    output logic                s_tready,
    input  logic                s_tlast,
    output logic [BLK_BITS-1:0] m_tdata,
    output logic                m_tvalid,
    input  logic                m_tready,
    output logic                m_tlast,
    output logic                encrypt_flag,
    output logic                decrypt_flag,
    output logic                key_expanded,
    output logic                aes_alg_en_key,
    output logic [KEY_BITS-1:0] aes_alg_key,
    output logic                aes128_mode,
    output logic                aes256_mode,
    input  logic                aes_alg_done,
    output logic [BLK_BITS-1:0] gcm_in_blk,
    output logic                gcm_valid,
    input  logic                gcm_ready,
    input  logic [BLK_BITS-1:0] gcm_out_blk,
    input  logic                gcm_out_store_blk,
    input  logic                gcm_done,
    output logic                controller_out_ready,
    output logic                err
);
    localparam int PW = $clog2(OUT_FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [2:0] {IDLE, GET_KEY, EXPAND, STREAM, WAIT_DONE, DRAIN} state_t;

    state_t            state, state_nxt;
    logic              s_fire, op_ok, proto_err;
    logic [BLK_BITS:0] mem [OUT_FIFO_DEPTH];
    logic [PW-1:0]     wptr, rptr;
    logic [CW-1:0]     count;
    logic              full, push, pop, overflow;

    assign s_fire      = s_tvalid && s_tready;
    assign op_ok       = s_tdata[0] ^ s_tdata[1];
    assign aes128_mode = 1'b1;
    assign aes256_mode = 1'b0;

    always_comb begin
        state_nxt = state;
        s_tready  = 1'b0;
        proto_err = 1'b0;
        case (state)
            IDLE: begin
                s_tready = 1'b1;
                if (s_tvalid) begin
                    if (s_tlast) begin
                        proto_err = 1'b1;
                    end else if (!op_ok) begin
                        proto_err = 1'b1;
                        state_nxt = DRAIN;
                    end else begin
                        state_nxt = GET_KEY;
                    end
                end
            end
            GET_KEY: begin
                s_tready = 1'b1;
                if (s_tvalid) begin
                    if (s_tlast) begin
                        proto_err = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = EXPAND;
                    end
                end
            end
            EXPAND: begin
                if (aes_alg_done) state_nxt = STREAM;
            end
            STREAM: begin
                s_tready = !gcm_valid || gcm_ready;
                if (s_tvalid && s_tready && s_tlast) state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (gcm_done) state_nxt = IDLE;
            end
            DRAIN: begin
                s_tready = 1'b1;
                if (s_tvalid && s_tlast) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // Hold off the host while reset is asserted.
        if (reset) s_tready = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            encrypt_flag   <= 1'b0;
            decrypt_flag   <= 1'b0;
            key_expanded   <= 1'b0;
            aes_alg_en_key <= 1'b0;
            aes_alg_key    <= '0;
            gcm_in_blk     <= '0;
            gcm_valid      <= 1'b0;
            err            <= 1'b0;
        end else begin
            state          <= state_nxt;
            aes_alg_en_key <= 1'b0;
            err            <= proto_err || overflow;
            if (state == IDLE && s_fire) begin
                encrypt_flag <= s_tdata[0];
                decrypt_flag <= s_tdata[1];
            end
            if (state == GET_KEY && s_fire && !s_tlast) begin
                aes_alg_key    <= {s_tdata, {(KEY_BITS-BLK_BITS){1'b0}}};
                aes_alg_en_key <= 1'b1;
            end
            if (state == EXPAND && aes_alg_done) key_expanded <= 1'b1;
            if (state == WAIT_DONE && gcm_done) begin
                key_expanded <= 1'b0;
                encrypt_flag <= 1'b0;
                decrypt_flag <= 1'b0;
            end
            // One-entry slice; keeps draining after the packet's last word is taken.
            if (state == STREAM && s_fire) begin
                gcm_in_blk <= s_tdata;
                gcm_valid  <= 1'b1;
            end else if (gcm_valid && gcm_ready) begin
                gcm_valid <= 1'b0;
            end
        end
    end

    assign full     = (count == CW'(OUT_FIFO_DEPTH));
    assign push     = gcm_out_store_blk && !full;
    assign overflow = gcm_out_store_blk && full;
    assign pop      = m_tvalid && m_tready;

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= {gcm_done, gcm_out_blk};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + PW'(1);
            if (pop)  rptr <= rptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Two free slots leave room for a store already issued by gcm.
    assign controller_out_ready = !reset && (count <= CW'(OUT_FIFO_DEPTH - 2));
    assign m_tvalid             = (count != '0);
    assign m_tdata              = m_tvalid ? mem[rptr][BLK_BITS-1:0] : '0;
    assign m_tlast              = m_tvalid && mem[rptr][BLK_BITS];

endmodule

// File: tb/tb_gcm_stream_ctrl.sv
// Bench for gcm_stream_ctrl: stand-in gcm/aes_top responders plus a packet-level model of the
// expected gcm input words and output blocks.
module tb_gcm_stream_ctrl;
    localparam int BW    = 128;
    localparam int KW    = 256;
    localparam int DEPTH = 8;
    typedef logic [BW-1:0] blk_t;
    typedef logic [BW:0]   cv_t;

    logic clk = 1'b0, reset = 1'b0;
    blk_t s_tdata = '0;
    logic s_tvalid = 1'b0, s_tready, s_tlast = 1'b0;
    blk_t m_tdata;
    logic m_tvalid, m_tready = 1'b0, m_tlast;
    logic encrypt_flag, decrypt_flag, key_expanded, aes_alg_en_key;
    logic [KW-1:0] aes_alg_key;
    logic aes128_mode, aes256_mode, aes_alg_done = 1'b0;
    blk_t gcm_in_blk, gcm_out_blk = '0;
    logic gcm_valid, gcm_ready = 1'b0, gcm_out_store_blk = 1'b0, gcm_done = 1'b0;
    logic controller_out_ready, err;

    gcm_stream_ctrl #(.BLK_BITS(BW), .KEY_BITS(KW), .OUT_FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
        .encrypt_flag(encrypt_flag), .decrypt_flag(decrypt_flag), .key_expanded(key_expanded),
        .aes_alg_en_key(aes_alg_en_key), .aes_alg_key(aes_alg_key),
        .aes128_mode(aes128_mode), .aes256_mode(aes256_mode), .aes_alg_done(aes_alg_done),
        .gcm_in_blk(gcm_in_blk), .gcm_valid(gcm_valid), .gcm_ready(gcm_ready),
        .gcm_out_blk(gcm_out_blk), .gcm_out_store_blk(gcm_out_store_blk), .gcm_done(gcm_done),
        .controller_out_ready(controller_out_ready), .err(err)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;
    int err_cnt = 0, en_cnt = 0, tag_cnt = 0, occ = 0, mrdy_mode = 2;
    blk_t       exp_gin[$];
    cv_t        exp_out[$];
    logic [1:0] exp_op[$];
    cv_t        st_q[$];
    blk_t       pk[$];

    task automatic chk(input string tag, input cv_t act, input cv_t exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Stand-in gcm keystream/tag; key 0 with J0 = 1 reproduces NIST GCM test case 2.
    function automatic blk_t ks(input blk_t key, input blk_t iv, input int i);
        logic [31:0] w;
        if (key == '0 && iv == 128'h1 && i == 0) return 128'h0388dace60b6a392f328c2b971b2fe78;
        w = 32'(i + 1) * 32'h9e3779b9;
        return key ^ {iv[63:0], iv[127:64]} ^ {w, w, w, w};
    endfunction

    function automatic blk_t tag_fn(input blk_t key, input blk_t iv, input blk_t acc);
        if (key == '0 && iv == 128'h1) return 128'hab6e47d42cec13bdf53a67b21257bddf;
        return key ^ iv ^ acc ^ 128'h5a5a_1234_c3c3_0f0f_a5a5_4321_3c3c_f0f0;
    endfunction

    function automatic blk_t rand_blk();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // gcm / aes_top responders, output sink and occupancy tracking.
    initial begin : env
        int rx, na, nd, done_cd;
        blk_t iv, acc, exp_w;
        cv_t exp_o;
        logic kx_chk, st_fire, pop_fire;
        rx = 0; na = 0; nd = 0; done_cd = 0; iv = '0; acc = '0; kx_chk = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                st_q.delete();
                rx = 0; acc = '0; done_cd = 0; occ = 0; kx_chk = 1'b0;
                gcm_out_store_blk = 1'b0; gcm_done = 1'b0; aes_alg_done = 1'b0;
                gcm_ready = 1'b0; m_tready = 1'b0;
                continue;
            end
            aes_alg_done = (done_cd == 1);
            if (done_cd > 0) done_cd--;
            gcm_ready = ($urandom_range(0, 3) != 0);
            m_tready  = (mrdy_mode == 0) ? ($urandom_range(0, 1) == 1) : (mrdy_mode == 2);
            gcm_out_store_blk = (st_q.size() != 0) && controller_out_ready;
            gcm_out_blk = gcm_out_store_blk ? st_q[0][BW-1:0] : '0;
            gcm_done    = gcm_out_store_blk && st_q[0][BW];
            #1;
            chk("out_rdy", cv_t'(controller_out_ready), cv_t'((DEPTH - occ) >= 2));
            chk("m_tvalid", cv_t'(m_tvalid), cv_t'(occ > 0));
            if (kx_chk) begin
                chk("kx_clr", cv_t'(key_expanded), cv_t'(1'b0));
                chk("flags_clr", cv_t'({decrypt_flag, encrypt_flag}), cv_t'(2'b00));
                chk("idle_rdy", cv_t'(s_tready), cv_t'(1'b1));
                kx_chk = 1'b0;
            end
            if (err) err_cnt++;
            if (aes_alg_en_key) begin
                en_cnt++;
                done_cd = $urandom_range(1, 4);
            end
            pop_fire = m_tvalid && m_tready;
            if (pop_fire) begin
                if (exp_out.size() != 0) exp_o = exp_out.pop_front();
                else exp_o = ~{m_tlast, m_tdata};
                chk("m_tdata", cv_t'(m_tdata), cv_t'(exp_o[BW-1:0]));
                chk("m_tlast", cv_t'(m_tlast), cv_t'(exp_o[BW]));
            end
            st_fire = gcm_out_store_blk;
            if (st_fire) begin
                if (st_q[0][BW]) begin
                    kx_chk = 1'b1;
                    tag_cnt++;
                end
                void'(st_q.pop_front());
            end
            if (gcm_valid && gcm_ready) begin
                if (exp_gin.size() != 0) exp_w = exp_gin.pop_front();
                else exp_w = ~gcm_in_blk;
                chk("gin", cv_t'(gcm_in_blk), cv_t'(exp_w));
                chk("kx_set", cv_t'(key_expanded), cv_t'(1'b1));
                chk("flags", cv_t'({decrypt_flag, encrypt_flag}),
                    cv_t'(exp_op.size() != 0 ? exp_op[0] : 2'b00));
                if (rx == 0) begin
                    iv = gcm_in_blk;
                end else if (rx == 1) begin
                    na = int'(gcm_in_blk[127:64] >> 7);
                    nd = int'(gcm_in_blk[63:0] >> 7);
                end else begin
                    acc ^= gcm_in_blk;
                    if (rx - 2 >= na)
                        st_q.push_back({1'b0, gcm_in_blk ^ ks(aes_alg_key[KW-1:KW-BW], iv, rx - 2 - na)});
                end
                rx++;
                if (rx >= 2 && rx == 2 + na + nd) begin
                    st_q.push_back({1'b1, tag_fn(aes_alg_key[KW-1:KW-BW], iv, acc)});
                    if (exp_op.size() != 0) void'(exp_op.pop_front());
                    rx = 0;
                    acc = '0;
                end
            end
            occ = occ + int'(st_fire) - int'(pop_fire);
        end
    end

    // Packet-level model: gcm sees words 2..N; outputs are data^keystream then the tag.
    task automatic build(input logic [1:0] op, input blk_t key, input blk_t iv, input int na,
                         input int nd, input blk_t dval, input bit rnd);
        blk_t acc, d;
        pk.delete();
        pk.push_back(blk_t'(op));
        pk.push_back(key);
        pk.push_back(iv);
        pk.push_back({64'(na * 128), 64'(nd * 128)});
        acc = '0;
        for (int i = 0; i < na + nd; i++) begin
            d = rnd ? rand_blk() : dval;
            pk.push_back(d);
            acc ^= d;
            if (i >= na) exp_out.push_back({1'b0, d ^ ks(key, iv, i - na)});
        end
        for (int i = 2; i < pk.size(); i++) exp_gin.push_back(pk[i]);
        exp_out.push_back({1'b1, tag_fn(key, iv, acc)});
        exp_op.push_back(op);
    endtask

    task automatic send(input int n);
        int cyc;
        bit done;
        for (int i = 0; i < n; i++) begin
            cyc = 0;
            done = 1'b0;
            while (!done) begin
                @(negedge clk);
                s_tvalid = ($urandom_range(0, 3) != 0);
                s_tdata  = pk[i];
                s_tlast  = (i == pk.size() - 1);
                #1;
                cyc++;
                done = s_tvalid && s_tready;
                if (!done && cyc > 300) begin
                    chk("src_to", cv_t'(cyc), cv_t'(0));
                    done = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic drain(input int budget);
        int cyc = 0;
        while ((exp_out.size() != 0 || exp_gin.size() != 0 || occ != 0) && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        chk("drain_to", cv_t'(exp_out.size()), cv_t'(0));
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_rst();
        chk("rst_s_tready", cv_t'(s_tready), cv_t'(1'b0));
        chk("rst_m_tvalid", cv_t'(m_tvalid), cv_t'(1'b0));
        chk("rst_m_tdata", cv_t'({m_tlast, m_tdata}), cv_t'(0));
        chk("rst_flags", cv_t'({decrypt_flag, encrypt_flag, key_expanded, aes_alg_en_key}), cv_t'(0));
        chk("rst_key", cv_t'(aes_alg_key[KW-1:KW-BW] | aes_alg_key[BW-1:0]), cv_t'(0));
        chk("rst_modes", cv_t'({aes128_mode, aes256_mode}), cv_t'(2'b10));
        chk("rst_gcm", cv_t'({gcm_valid, gcm_in_blk}), cv_t'(0));
        chk("rst_misc", cv_t'({controller_out_ready, err}), cv_t'(0));
    endtask

    initial begin : main
        int e0, n0, t0, cyc;
        #1 reset = 1'b1;
        #5 chk_rst();
        @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        #1 chk("idle_s_tready", cv_t'(s_tready), cv_t'(1'b1));

        // NIST GCM case 2, encrypt then decrypt
        n0 = en_cnt;
        build(2'd1, '0, 128'h1, 0, 1, '0, 1'b0);
        send(pk.size());
        drain(500);
        chk("enc_en_key", cv_t'(en_cnt - n0), cv_t'(1));
        build(2'd2, '0, 128'h1, 0, 1, 128'h0388dace60b6a392f328c2b971b2fe78, 1'b0);
        send(pk.size());
        drain(500);

        // Protocol errors: bad op 3, op 0 alone, tlast on OP, tlast on key
        e0 = err_cnt; n0 = en_cnt;
        pk.delete();
        pk.push_back(blk_t'(3));
        for (int i = 0; i < 3; i++) pk.push_back(rand_blk());
        send(4);
        repeat (4) @(negedge clk);
        #1;
        chk("badop_err", cv_t'(err_cnt - e0), cv_t'(1));
        chk("badop_en", cv_t'(en_cnt - n0), cv_t'(0));
        chk("badop_idle", cv_t'(s_tready), cv_t'(1'b1));
        pk.delete();
        pk.push_back(blk_t'(0));
        send(1);
        pk.delete();
        pk.push_back(blk_t'(1));
        send(1);
        pk.delete();
        pk.push_back(blk_t'(1));
        pk.push_back(rand_blk());
        send(2);
        repeat (4) @(negedge clk);
        #1;
        chk("tlast_err", cv_t'(err_cnt - e0), cv_t'(4));
        chk("tlast_en", cv_t'(en_cnt - n0), cv_t'(0));

        // Output backpressure: 6 data blocks + tag fill 7 of 8 entries
        e0 = err_cnt;
        mrdy_mode = 1;
        build(2'd1, rand_blk(), rand_blk(), 0, 6, '0, 1'b1);
        send(pk.size());
        t0 = tag_cnt; cyc = 0;
        while (tag_cnt == t0 && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        chk("bp_tag", cv_t'(tag_cnt - t0), cv_t'(1));
        repeat (3) @(negedge clk);
        #1;
        chk("bp_out_rdy", cv_t'(controller_out_ready), cv_t'(1'b0));
        chk("bp_occ", cv_t'(occ), cv_t'(7));
        chk("bp_err", cv_t'(err_cnt - e0), cv_t'(0));
        mrdy_mode = 2;
        drain(500);

        // Random back-to-back packets with random gaps everywhere
        mrdy_mode = 0;
        e0 = err_cnt;
        for (int p = 0; p < 10; p++) begin
            build(2'($urandom_range(1, 2)), rand_blk(), rand_blk(),
                  int'($urandom_range(0, 2)), int'($urandom_range(0, 4)), '0, 1'b1);
            send(pk.size());
        end
        drain(3000);
        chk("rnd_err", cv_t'(err_cnt - e0), cv_t'(0));
        mrdy_mode = 2;

        // Reset while streaming, then a clean packet
        build(2'd1, rand_blk(), rand_blk(), 0, 4, '0, 1'b1);
        send(6);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        exp_out.delete();
        exp_gin.delete();
        exp_op.delete();
        #4 chk_rst();
        @(posedge clk);
        #2 reset = 1'b0;
        build(2'd1, '0, 128'h1, 0, 1, '0, 1'b0);
        send(pk.size());
        drain(500);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/gcm_stream_ctrl.md
Name: gcm_stream_ctrl

Overview:
- Packet-level controller that drives the gcm block and the shared aes_top key schedule from a 128-bit input stream, and returns GCM results on a 128-bit output stream.
- Sits between the host-side stream interface and gcm.
- Per packet it:
  - decodes the operation word;
  - loads and expands the key;
  - forwards IV, AADLEN, AAD and data blocks to gcm;
  - buffers gcm output blocks, ending with the tag, in an output FIFO.

Parameters:
BLK_BITS, 128, stream word and GCM block width
KEY_BITS, 256, width of aes_alg_key (128-bit keys placed in the upper half)
OUT_FIFO_DEPTH, 8, output FIFO entries; power of two, >= 4

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
s_tdata  in  BLK_BITS  input stream word
s_tvalid  in  1  input word valid
s_tready  out  1  input word accepted when s_tvalid && s_tready
s_tlast  in  1  last word of packet
m_tdata  out  BLK_BITS  output block
m_tvalid  out  1  output valid
m_tready  in  1  downstream ready
m_tlast  out  1  marks tag block
encrypt_flag  out  1  to gcm
decrypt_flag  out  1  to gcm
key_expanded  out  1  to gcm; key schedule valid for current packet
aes_alg_en_key  out  1  one-cycle key expansion start
aes_alg_key  out  KEY_BITS  key to aes_top
aes128_mode  out  1  to aes_top
aes256_mode  out  1  to aes_top
aes_alg_done  in  1  aes_top en_o
gcm_in_blk  out  BLK_BITS  to gcm
gcm_valid  out  1  to gcm
gcm_ready  in  1  from gcm
gcm_out_blk  in  BLK_BITS  from gcm
gcm_out_store_blk  in  1  from gcm, output block strobe
gcm_done  in  1  from gcm, asserted in the same cycle as the tag store
controller_out_ready  out  1  to gcm
err  out  1  one-cycle protocol error pulse

Behaviour:
- Clock and reset: single clock clk. reset is asynchronous and active-high.
- Reset values:
  - All outputs 0, except aes128_mode = 1.
  - State = IDLE; FIFO empty.
  - aes_alg_key = 0.
- Packet format on s_*, one word per beat:
  - Word 0: OP. Bit0 = encrypt, bit1 = decrypt.
  - Word 1: K, 128-bit key.
  - Remaining words: IV, AADLEN, AAD, DATA_IN. s_tlast is set on the final word.
- State IDLE:
  - s_tready = 1.
  - On accept, latch encrypt_flag/decrypt_flag.
  - Valid op is exactly one of the two bits set. Valid op and !s_tlast -> GET_KEY.
  - Op 00 or 11 -> err pulse, go to DRAIN.
  - s_tlast on the OP word -> err pulse, stay in IDLE.
- State GET_KEY:
  - s_tready = 1.
  - On accept: aes_alg_key <= {s_tdata, 128'b0}; aes_alg_en_key pulses the next cycle; go to EXPAND.
  - s_tlast on the key word -> err pulse, go to IDLE.
- State EXPAND:
  - s_tready = 0.
  - On aes_alg_done: key_expanded <= 1, go to STREAM.
  - aes_alg_done is ignored in every other state.
- State STREAM: one-entry register slice.
  - s_tready = !gcm_valid || gcm_ready.
  - On s accept: gcm_in_blk <= s_tdata and gcm_valid <= 1.
  - Otherwise, gcm_valid clears when gcm_valid && gcm_ready.
  - gcm_in_blk holds while gcm_valid && !gcm_ready.
  - Accepting s_tlast -> WAIT_DONE. The slice still drains normally.
- State WAIT_DONE:
  - s_tready = 0.
  - On gcm_done: key_expanded <= 0, encrypt_flag/decrypt_flag <= 0, go to IDLE.
- State DRAIN:
  - s_tready = 1; words are discarded.
  - Accepting s_tlast -> IDLE.
- Output FIFO:
  - Width BLK_BITS + 1. Write on gcm_out_store_blk; stored last bit = gcm_done.
  - m_tvalid = !empty; m_tdata/m_tlast come from the head entry. Pop on m_tvalid && m_tready.
  - controller_out_ready = (free entries >= 2), computed from the registered count. This guarantees room for one in-flight store.
  - A write while full sets err, and the block is dropped.
  - Simultaneous push and pop leaves the count unchanged. Pointers wrap modulo OUT_FIFO_DEPTH.
- Back-to-back packets: the next OP word is accepted in the cycle after the return to IDLE, while the FIFO may still hold the previous packet's blocks.
- Reset mid-operation returns to IDLE immediately. This clears key_expanded, gcm_valid and the FIFO, and discards any partial packet.

Test Plan:
- Encrypt, NIST GCM case 2: OP=1, K=0, IV/AADLEN per vector, PT=0 -> m_tdata 0388dace60b6a392f328c2b971b2fe78 (m_tlast=0), then ab6e47d42cec13bdf53a67b21257bddf (m_tlast=1); key_expanded falls on gcm_done.
- Decrypt of the same case: OP=2, CT=0388dace... -> plaintext 0, then tag ab6e47d4...; encrypt_flag=0, decrypt_flag=1 throughout.
- Backpressure: hold m_tready=0 with a 6-data-block packet on depth 8 -> controller_out_ready falls at 7 entries, no err, no lost block; release -> all blocks arrive in order.
- Bad op 3 in a 4-word packet -> err pulse once, all 4 words accepted and discarded, no aes_alg_en_key; the next valid packet processes correctly.
- Random s_tvalid/gcm_ready gaps -> gcm_in_blk sequence equals input words 2..N with no duplicates or drops.
- Assert reset during STREAM -> all outputs return to their reset values; m_tvalid=0; the next packet passes.
